ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have port clk, input, 1 bit, the single clock; rising edge only.
REQ-002 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-003 SHALL have port exception, input, 1 bit, pipeline flush; aborts any in-flight divide.
REQ-004 SHALL have inputs ex_pc/ex_rs_data/ex_rt_data/ex_instr (32 each) and ex_aluop (8), all from the ID/EX register.
REQ-005 SHALL have inputs ex_sign_extend_imm16/ex_zero_extend_imm16/ex_load_upper_imm16 (32 each) and ex_hilo_data (32): current HI or LO, selected upstream.
REQ-006 SHALL have inputs ex_regfile_write_addr (5), ex_regfile_write_enable (1), ex_hi_write_enable (1), ex_lo_write_enable (1) and ex_exception_type (32).
REQ-007 SHALL have output ex_result, 32 bits: GPR writeback or store data.
REQ-008 SHALL have outputs ex_hi_data/ex_lo_data, 32 each: HI/LO write values.
REQ-009 SHALL have output ex_regfile_write_enable_o, 1 bit: ex_regfile_write_enable, gated by overflow.
REQ-010 SHALL have output ex_exception_type_o, 32 bits: the input value OR the overflow bit.
REQ-011 SHALL have output ex_stall_req, 1 bit: drives stall[2] (exe_stall).

Function
REQ-012 Single-cycle ops are combinational, zero latency: ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU, SLL, SRL, SRA, SLLV, SRLV, SRAV, LUI, MFHI, MFLO, MTHI, MTLO, MULT, MULTU.
REQ-013 Immediate ops use the zero-extended immediate for ANDI/ORI/XORI, the sign-extended immediate for ADDI/ADDIU/SLTI/SLTIU, and ex_load_upper_imm16 for LUI.
REQ-014 Shift amount is ex_instr[10:6] for fixed shifts and ex_rs_data[4:0] for variable shifts.
REQ-015 MULT/MULTU produce a 64-bit product: {ex_hi_data, ex_lo_data}, signed or unsigned respectively.
REQ-016 On signed overflow of ADD/ADDI/SUB, bit OVF_BIT of ex_exception_type_o SHALL be set and ex_regfile_write_enable_o SHALL be 0; ADDU/SUBU never trap.
REQ-017 DIV/DIVU use a divider FSM with states IDLE, BUSY, DONE.
REQ-018 IDLE -> BUSY: DIV/DIVU present, divisor nonzero, exception=0. ex_stall_req=1 combinationally in that cycle; iteration counter loads 0.
REQ-019 BUSY: one restoring-division step per cycle on magnitudes; ex_stall_req=1. The 32nd step (counter=31) moves to DONE.
REQ-020 DONE: ex_stall_req=0; ex_lo_data=quotient and ex_hi_data=remainder are valid; next edge -> IDLE unconditionally.
REQ-021 Divide latency: issue cycle N, stall N..N+32, results in N+33 (34 cycles total).
REQ-022 Signed divide: quotient is negated if the operand signs differ; remainder takes the dividend's sign. 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-023 Divisor zero: no FSM entry, ex_stall_req=0, LO=0, HI=ex_rs_data, completes in a single cycle.
REQ-024 exception=1 in any state: FSM -> IDLE on the next edge, and ex_stall_req SHALL be 0 in that same cycle.
REQ-025 Operands are latched on IDLE->BUSY; input changes during BUSY SHALL be ignored.

Reset
REQ-026 rst=0 asynchronously sets FSM=IDLE and the counter, dividend, divisor, sign flags and partial remainder to 0.
REQ-027 During reset ex_stall_req=0; the combinational outputs follow their inputs.
REQ-028 Reset mid-divide discards the divide with no output glitch to DONE.

Configuration
REQ-029 Macro EX_HW_DIV_EN SHALL control the divider.
REQ-030 With EX_HW_DIV_EN defined, the divider and its FSM SHALL be present as specified above.
REQ-031 With EX_HW_DIV_EN undefined, there is no FSM and ex_stall_req is tied 0. DIV/DIVU set bit RI_BIT of ex_exception_type_o, and the HI/LO write enables seen by the pipeline are unaffected by this block.

Structure
REQ-032 The ALUOP codes, OVF_BIT, RI_BIT and the divider state encodings SHALL live in the shared defines.v.
REQ-033 The divider (FSM, counter, datapath) SHALL be the sub-module ex_div, instantiated under EX_HW_DIV_EN.

Verification
REQ-034 ADD with 0x7FFFFFFF + 1 -> OVF_BIT set, write enable 0; ADDU with the same operands -> 0x80000000, write enable 1.
REQ-035 DIVU 100/7 -> stall high 33 cycles, then LO=14, HI=2 with stall low; FSM back in IDLE the next cycle.
REQ-036 DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
REQ-037 DIV x/0 -> no stall, LO=0, HI=x in the same cycle.
REQ-038 exception pulse at BUSY step 10 -> stall drops the same cycle; a following DIVU 9/3 -> LO=3, HI=0.
REQ-039 rst=0 asserted at BUSY step 20 -> immediately IDLE, stall 0; MULT 0xFFFFFFFF x 2 -> HI=0xFFFFFFFF, LO=0xFFFFFFFE.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op codes, exception bit positions,
// divider state encodings and small arithmetic helpers. Divider built only with EX_HW_DIV_EN.
package ex_stage_pkg;

    localparam logic [7:0] AluNop   = 8'h00;
    localparam logic [7:0] AluSll   = 8'h01;
    localparam logic [7:0] AluSrl   = 8'h02;
    localparam logic [7:0] AluSra   = 8'h03;
    localparam logic [7:0] AluSllv  = 8'h04;
    localparam logic [7:0] AluSrlv  = 8'h05;
    localparam logic [7:0] AluSrav  = 8'h06;
    localparam logic [7:0] AluLui   = 8'h07;
    localparam logic [7:0] AluMfhi  = 8'h10;
    localparam logic [7:0] AluMthi  = 8'h11;
    localparam logic [7:0] AluMflo  = 8'h12;
    localparam logic [7:0] AluMtlo  = 8'h13;
    localparam logic [7:0] AluMult  = 8'h18;
    localparam logic [7:0] AluMultu = 8'h19;
    localparam logic [7:0] AluDiv   = 8'h1A;
    localparam logic [7:0] AluDivu  = 8'h1B;
    localparam logic [7:0] AluAdd   = 8'h20;
    localparam logic [7:0] AluAddu  = 8'h21;
    localparam logic [7:0] AluSub   = 8'h22;
    localparam logic [7:0] AluSubu  = 8'h23;
    localparam logic [7:0] AluAnd   = 8'h24;
    localparam logic [7:0] AluOr    = 8'h25;
    localparam logic [7:0] AluXor   = 8'h26;
    localparam logic [7:0] AluNor   = 8'h27;
    localparam logic [7:0] AluSlt   = 8'h2A;
    localparam logic [7:0] AluSltu  = 8'h2B;
    localparam logic [7:0] AluAddi  = 8'h30;
    localparam logic [7:0] AluAddiu = 8'h31;
    localparam logic [7:0] AluSlti  = 8'h32;
    localparam logic [7:0] AluSltiu = 8'h33;
    localparam logic [7:0] AluAndi  = 8'h34;
    localparam logic [7:0] AluOri   = 8'h35;
    localparam logic [7:0] AluXori  = 8'h36;

    localparam int unsigned RiBit  = 9;
    localparam int unsigned OvfBit = 11;

    typedef enum logic [1:0] {
        DivIdle = 2'd0,
        DivBusy = 2'd1,
        DivDone = 2'd2
    } div_state_e;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

    function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] s);
        return (a[31] == b[31]) && (s[31] != a[31]);
    endfunction

    function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b,
                                     input logic [31:0] d);
        return (a[31] != b[31]) && (d[31] != a[31]);
    endfunction

endpackage

// File: rtl/ex_div.sv
// Multi-cycle restoring divider: latches operand magnitudes and signs, runs 32 steps,
// then presents quotient/remainder for one DONE cycle.
module ex_div
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic        div_op,
    input  logic        div_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        stall,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    div_state_e  state_q;
    logic [4:0]  cnt_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;
    logic [31:0] rem_q;
    logic        neg_quo_q;
    logic        neg_rem_q;
    logic        start;
    logic [32:0] trial;

    assign start = (state_q == DivIdle) && div_op && (divisor != 32'd0) && !exception;
    // Shift the next dividend bit into the partial remainder and try subtracting.
    assign trial = {rem_q, dvd_q[31]} - {1'b0, dsr_q};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DivIdle;
            cnt_q     <= 5'd0;
            dvd_q     <= 32'd0;
            dsr_q     <= 32'd0;
            rem_q     <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (exception) begin
            state_q <= DivIdle;
        end else begin
            case (state_q)
                DivIdle: begin
                    if (start) begin
                        state_q   <= DivBusy;
                        cnt_q     <= 5'd0;
                        dvd_q     <= abs32(dividend, div_signed);
                        dsr_q     <= abs32(divisor, div_signed);
                        rem_q     <= 32'd0;
                        neg_quo_q <= div_signed && (dividend[31] ^ divisor[31]);
                        neg_rem_q <= div_signed && dividend[31];
                    end
                end
                DivBusy: begin
                    rem_q <= trial[32] ? {rem_q[30:0], dvd_q[31]} : trial[31:0];
                    dvd_q <= {dvd_q[30:0], ~trial[32]};
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_q <= DivDone;
                    end
                end
                DivDone: state_q <= DivIdle;
                default: state_q <= DivIdle;
            endcase
        end
    end

    assign stall     = rst && !exception && (start || (state_q == DivBusy));
    assign done      = (state_q == DivDone);
    assign quotient  = neg_quo_q ? (~dvd_q + 32'd1) : dvd_q;
    assign remainder = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: single-cycle ALU, shifter and multiplier; DIV/DIVU via ex_div when
// EX_HW_DIV_EN is defined, otherwise DIV/DIVU raise the reserved-instruction bit.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        exception,
    input  logic [31:0] ex_pc,
    input  logic [31:0] ex_rs_data,
    input  logic [31:0] ex_rt_data,
    input  logic [31:0] ex_instr,
    input  logic [7:0]  ex_aluop,
    input  logic [31:0] ex_sign_extend_imm16,
    input  logic [31:0] ex_zero_extend_imm16,
    input  logic [31:0] ex_load_upper_imm16,
    input  logic [31:0] ex_hilo_data,
    input  logic [4:0]  ex_regfile_write_addr,
    input  logic        ex_regfile_write_enable,
    input  logic        ex_hi_write_enable,
    input  logic        ex_lo_write_enable,
    input  logic [31:0] ex_exception_type,
    output logic [31:0] ex_result,
    output logic [31:0] ex_hi_data,
    output logic [31:0] ex_lo_data,
    output logic        ex_regfile_write_enable_o,
    output logic [31:0] ex_exception_type_o,
    output logic        ex_stall_req
);

    logic [4:0]  shamt;
    logic [4:0]  shamt_v;
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic        ovf;
    logic        ri;
    logic        unused_ok;

    assign shamt   = ex_instr[10:6];
    assign shamt_v = ex_rs_data[4:0];
    assign prod_s  = $signed({{32{ex_rs_data[31]}}, ex_rs_data})
                   * $signed({{32{ex_rt_data[31]}}, ex_rt_data});
    assign prod_u  = {32'd0, ex_rs_data} * {32'd0, ex_rt_data};

`ifdef EX_HW_DIV_EN
    logic        div_op;
    logic        div_done;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    assign div_op = (ex_aluop == AluDiv) || (ex_aluop == AluDivu);

    ex_div u_div (
        .clk        (clk),
        .rst        (rst),
        .exception  (exception),
        .div_op     (div_op),
        .div_signed (ex_aluop == AluDiv),
        .dividend   (ex_rs_data),
        .divisor    (ex_rt_data),
        .stall      (ex_stall_req),
        .done       (div_done),
        .quotient   (div_quotient),
        .remainder  (div_remainder)
    );

    assign unused_ok = ^{ex_pc, ex_instr, ex_regfile_write_addr, ex_hi_write_enable,
                         ex_lo_write_enable};
`else
    assign ex_stall_req = 1'b0;
    assign unused_ok = ^{ex_pc, ex_instr, ex_regfile_write_addr, ex_hi_write_enable,
                         ex_lo_write_enable, clk, rst, exception};
`endif

    always_comb begin
        ex_result  = 32'd0;
        ex_hi_data = 32'd0;
        ex_lo_data = 32'd0;
        ovf        = 1'b0;
        ri         = 1'b0;
        case (ex_aluop)
            AluAdd, AluAddu: begin
                ex_result = ex_rs_data + ex_rt_data;
                ovf = (ex_aluop == AluAdd) && add_ovf(ex_rs_data, ex_rt_data, ex_result);
            end
            AluAddi, AluAddiu: begin
                ex_result = ex_rs_data + ex_sign_extend_imm16;
                ovf = (ex_aluop == AluAddi)
                    && add_ovf(ex_rs_data, ex_sign_extend_imm16, ex_result);
            end
            AluSub, AluSubu: begin
                ex_result = ex_rs_data - ex_rt_data;
                ovf = (ex_aluop == AluSub) && sub_ovf(ex_rs_data, ex_rt_data, ex_result);
            end
            AluAnd:   ex_result = ex_rs_data & ex_rt_data;
            AluOr:    ex_result = ex_rs_data | ex_rt_data;
            AluXor:   ex_result = ex_rs_data ^ ex_rt_data;
            AluNor:   ex_result = ~(ex_rs_data | ex_rt_data);
            AluAndi:  ex_result = ex_rs_data & ex_zero_extend_imm16;
            AluOri:   ex_result = ex_rs_data | ex_zero_extend_imm16;
            AluXori:  ex_result = ex_rs_data ^ ex_zero_extend_imm16;
            AluSlt:   ex_result = {31'd0, $signed(ex_rs_data) < $signed(ex_rt_data)};
            AluSltu:  ex_result = {31'd0, ex_rs_data < ex_rt_data};
            AluSlti:  ex_result = {31'd0, $signed(ex_rs_data) < $signed(ex_sign_extend_imm16)};
            AluSltiu: ex_result = {31'd0, ex_rs_data < ex_sign_extend_imm16};
            AluSll:   ex_result = ex_rt_data << shamt;
            AluSrl:   ex_result = ex_rt_data >> shamt;
            AluSra:   ex_result = 32'($signed(ex_rt_data) >>> shamt);
            AluSllv:  ex_result = ex_rt_data << shamt_v;
            AluSrlv:  ex_result = ex_rt_data >> shamt_v;
            AluSrav:  ex_result = 32'($signed(ex_rt_data) >>> shamt_v);
            AluLui:   ex_result = ex_load_upper_imm16;
            AluMfhi, AluMflo: ex_result = ex_hilo_data;
            AluMthi:  ex_hi_data = ex_rs_data;
            AluMtlo:  ex_lo_data = ex_rs_data;
            AluMult:  {ex_hi_data, ex_lo_data} = prod_s;
            AluMultu: {ex_hi_data, ex_lo_data} = prod_u;
            AluDiv, AluDivu: begin
`ifdef EX_HW_DIV_EN
                // A zero divisor never enters the FSM and resolves in the issue cycle.
                if (!div_done && (ex_rt_data == 32'd0)) begin
                    ex_lo_data = 32'd0;
                    ex_hi_data = ex_rs_data;
                end else begin
                    ex_lo_data = div_quotient;
                    ex_hi_data = div_remainder;
                end
`else
                ri = 1'b1;
`endif
            end
            default: ex_result = 32'd0;
        endcase
    end

    always_comb begin
        ex_exception_type_o = ex_exception_type;
        if (ovf) ex_exception_type_o[OvfBit] = 1'b1;
        if (ri)  ex_exception_type_o[RiBit]  = 1'b1;
        ex_regfile_write_enable_o = ex_regfile_write_enable && !ovf;
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; divider scenarios run when EX_HW_DIV_EN is set.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk;
    logic        rst;
    logic        exception;
    logic [31:0] pc, rs, rt, instr, sext, zext, lui, hilo, exc_in;
    logic [7:0]  aluop;
    logic [4:0]  waddr;
    logic        we, hi_we, lo_we;
    logic [31:0] ex_result, ex_hi_data, ex_lo_data, ex_exception_type_o;
    logic        ex_regfile_write_enable_o, ex_stall_req;

    int n_checks = 0;
    int n_errors = 0;

    ex_stage dut (
        .clk                       (clk),
        .rst                       (rst),
        .exception                 (exception),
        .ex_pc                     (pc),
        .ex_rs_data                (rs),
        .ex_rt_data                (rt),
        .ex_instr                  (instr),
        .ex_aluop                  (aluop),
        .ex_sign_extend_imm16      (sext),
        .ex_zero_extend_imm16      (zext),
        .ex_load_upper_imm16       (lui),
        .ex_hilo_data              (hilo),
        .ex_regfile_write_addr     (waddr),
        .ex_regfile_write_enable   (we),
        .ex_hi_write_enable        (hi_we),
        .ex_lo_write_enable        (lo_we),
        .ex_exception_type         (exc_in),
        .ex_result                 (ex_result),
        .ex_hi_data                (ex_hi_data),
        .ex_lo_data                (ex_lo_data),
        .ex_regfile_write_enable_o (ex_regfile_write_enable_o),
        .ex_exception_type_o       (ex_exception_type_o),
        .ex_stall_req              (ex_stall_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic alu(input string tag, input logic [7:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res);
        aluop = op;
        rs    = a;
        rt    = b;
        #1;
        check_eq(tag, ex_result, exp_res);
    endtask

    // Issue a divide from IDLE, count stall cycles, check results in the DONE cycle.
    task automatic run_div(input string tag, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi, input bit reissue);
        int n = 0;
        @(posedge clk); #1;
        aluop = op;
        rs    = a;
        rt    = b;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ex_stall_req) n++;
            else break;
        end
        check_eq({tag, "_stall_cycles"}, n, 33);
        check_eq({tag, "_lo"}, ex_lo_data, exp_lo);
        check_eq({tag, "_hi"}, ex_hi_data, exp_hi);
        @(posedge clk); #1;
        if (reissue) begin
            // Back in IDLE with the divide still presented: a fresh issue must stall.
            check_eq({tag, "_idle_reissue"}, ex_stall_req, 1);
            exception = 1'b1;
            @(posedge clk); #1;
            exception = 1'b0;
        end
        aluop = AluNop;
    endtask

    initial begin
        rst = 1'b0; exception = 1'b0;
        pc = 32'h0000_1000; rs = '0; rt = '0; instr = '0;
        sext = '0; zext = '0; lui = '0; hilo = '0; exc_in = '0;
        aluop = AluDivu; waddr = 5'd3; we = 1'b1; hi_we = 1'b0; lo_we = 1'b0;

        // During reset: no stall even with a divide presented; datapath still live.
        rs = 32'd100; rt = 32'd7;
        #12;
        check_eq("reset_stall", ex_stall_req, 0);
        alu("reset_addu", AluAddu, 32'd1, 32'd2, 32'd3);
        aluop = AluNop;
        @(negedge clk);
        rst = 1'b1;
        #1;

        alu("add_ovf_res", AluAdd, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        check_eq("add_ovf_exc", ex_exception_type_o, 32'h0000_0800);
        check_eq("add_ovf_we", ex_regfile_write_enable_o, 0);
        exc_in = 32'h0000_0100;
        #1;
        check_eq("add_ovf_exc_or", ex_exception_type_o, 32'h0000_0900);
        exc_in = 32'h0;
        alu("addu_res", AluAddu, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000);
        check_eq("addu_we", ex_regfile_write_enable_o, 1);
        check_eq("addu_exc", ex_exception_type_o, 32'h0);
        alu("sub_ovf_res", AluSub, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF);
        check_eq("sub_ovf_we", ex_regfile_write_enable_o, 0);
        alu("subu", AluSubu, 32'd5, 32'd7, 32'hFFFF_FFFE);
        check_eq("subu_we", ex_regfile_write_enable_o, 1);
        alu("and", AluAnd, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        alu("or",  AluOr,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hFFF0_FFF0);
        alu("xor", AluXor, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        alu("nor", AluNor, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h000F_000F);
        alu("slt",  AluSlt,  32'hFFFF_FFFF, 32'd1, 32'd1);
        alu("sltu", AluSltu, 32'hFFFF_FFFF, 32'd1, 32'd0);

        instr = 32'h0000_07C0;  // shamt 31
        alu("sll31", AluSll, 32'd0, 32'd1, 32'h8000_0000);
        instr = 32'h0000_0100;  // shamt 4
        alu("sra4", AluSra, 32'd0, 32'h8000_0000, 32'hF800_0000);
        alu("srl4", AluSrl, 32'd0, 32'h8000_0000, 32'h0800_0000);
        alu("srav", AluSrav, 32'h0000_0024, 32'h8000_0000, 32'hF800_0000);
        alu("sllv", AluSllv, 32'h0000_0021, 32'd3, 32'd6);
        alu("srlv", AluSrlv, 32'd8, 32'h0000_FF00, 32'h0000_00FF);

        lui = 32'h1234_0000;
        alu("lui", AluLui, 32'd0, 32'd0, 32'h1234_0000);
        zext = 32'h0000_FFFF;
        alu("andi", AluAndi, 32'h1234_5678, 32'd0, 32'h0000_5678);
        zext = 32'h0000_F000;
        alu("ori", AluOri, 32'h1234_5678, 32'd0, 32'h1234_F678);
        sext = 32'hFFFF_FFFF;
        alu("addi_neg", AluAddi, 32'd0, 32'd0, 32'hFFFF_FFFF);
        alu("slti", AluSlti, 32'hFFFF_FFFE, 32'd0, 32'd1);
        alu("sltiu", AluSltiu, 32'd1, 32'd0, 32'd1);
        sext = 32'd1;
        alu("addi_ovf_res", AluAddi, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000);
        check_eq("addi_ovf_we", ex_regfile_write_enable_o, 0);
        alu("addiu", AluAddiu, 32'h7FFF_FFFF, 32'd0, 32'h8000_0000);
        check_eq("addiu_we", ex_regfile_write_enable_o, 1);

        hilo = 32'h0000_CAFE;
        alu("mfhi", AluMfhi, 32'd0, 32'd0, 32'h0000_CAFE);
        alu("mthi", AluMthi, 32'h0000_00AA, 32'd0, 32'd0);
        check_eq("mthi_hi", ex_hi_data, 32'h0000_00AA);
        alu("mult", AluMult, 32'hFFFF_FFFF, 32'd2, 32'd0);
        check_eq("mult_hilo", {ex_hi_data, ex_lo_data}, 64'hFFFF_FFFF_FFFF_FFFE);
        alu("multu", AluMultu, 32'hFFFF_FFFF, 32'd2, 32'd0);
        check_eq("multu_hilo", {ex_hi_data, ex_lo_data}, 64'h0000_0001_FFFF_FFFE);
        aluop = AluNop;

`ifdef EX_HW_DIV_EN
        run_div("divu_100_7", AluDivu, 32'd100, 32'd7, 32'd14, 32'd2, 1'b1);
        run_div("div_m7_2", AluDiv, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        run_div("div_min_m1", AluDiv, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,
                1'b0);

        @(posedge clk); #1;
        alu("div_by0_res", AluDiv, 32'h1234_5678, 32'd0, 32'd0);
        check_eq("div_by0_stall", ex_stall_req, 0);
        check_eq("div_by0_hilo", {ex_hi_data, ex_lo_data}, 64'h1234_5678_0000_0000);
        aluop = AluNop;

        // Exception at BUSY step 10.
        @(posedge clk); #1;
        aluop = AluDivu; rs = 32'd100; rt = 32'd7;
        repeat (11) @(posedge clk);
        #1;
        check_eq("busy10_stall", ex_stall_req, 1);
        exception = 1'b1;
        #1;
        check_eq("exc_stall", ex_stall_req, 0);
        @(posedge clk); #1;
        exception = 1'b0;
        aluop = AluNop;
        run_div("divu_9_3", AluDivu, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);

        // Reset at BUSY step 20.
        @(posedge clk); #1;
        aluop = AluDivu; rs = 32'd100; rt = 32'd7;
        repeat (21) @(posedge clk);
        #1;
        check_eq("busy20_stall", ex_stall_req, 1);
        rst = 1'b0;
        #1;
        check_eq("rst_mid_stall", ex_stall_req, 0);
        aluop = AluMult; rs = 32'hFFFF_FFFF; rt = 32'd2;
        #1;
        rst = 1'b1;
        #1;
        check_eq("rst_mult_hilo", {ex_hi_data, ex_lo_data}, 64'hFFFF_FFFF_FFFF_FFFE);
        check_eq("rst_after_stall", ex_stall_req, 0);
        aluop = AluNop;
        run_div("divu_after_rst", AluDivu, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
`else
        alu("div_ri_res", AluDiv, 32'd10, 32'd2, 32'd0);
        check_eq("div_ri_exc", ex_exception_type_o, 32'h0000_0200);
        check_eq("div_ri_stall", ex_stall_req, 0);
        alu("divu_ri_res", AluDivu, 32'd10, 32'd0, 32'd0);
        check_eq("divu_ri_exc", ex_exception_type_o, 32'h0000_0200);
        aluop = AluNop;
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
